// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, LSB-first data, optional even parity, stop bit.
// Sampling happens only on en strobes; result pulses are one clk wide.
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic                par_q, par_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dv_q, dv_d;
  logic                pe_q, pe_d;
  logic                fe_q, fe_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    par_d   = par_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;

    if (en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!sin) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end

        S_DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) sr_d[i] = sin;
          end
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_PARITY: begin
          par_d   = sin;
          state_d = S_STOP;
        end

        S_STOP: begin
          if (sin) begin
            dout_d  = sr_q;
            dv_d    = 1'b1;
            // Even parity: odd count of ones across data plus parity bit is an error.
            pe_d    = (PARITY_EN != 0) ? ((^sr_q) ^ par_q) : 1'b0;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end

        S_WAIT_HIGH: begin
          if (sin) state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      busy_q  <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx (DATA_W=8, even parity): directed table, corner sequences,
// and random frames checked against a frame-level model.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       en;
  logic [7:0] dout;
  logic       dout_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .en         (en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         period;
    logic [7:0] exp_dout;
    logic       exp_dv;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         dv_seen = 0, fe_seen = 0, pe_seen = 0;
  int         exp_dv_total = 0, exp_fe_total = 0, exp_pe_total = 0;
  logic       prev_dv = 1'b0, prev_fe = 1'b0;
  logic [7:0] model_dout = 8'h00;
  logic       hold_bad = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock step; also watches pulse shape on every cycle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (dout_valid) begin
      dv_seen++;
      check("dv_one_cycle", prev_dv, 0);
    end
    if (frame_err) begin
      fe_seen++;
      check("fe_one_cycle", prev_fe, 0);
      check("fe_without_dv", dout_valid, 0);
    end
    if (parity_err) begin
      pe_seen++;
      check("pe_with_dv", dout_valid, 1);
    end
    prev_dv = dout_valid;
    prev_fe = frame_err;
  endtask

  // Present one bit; en is high only in the last cycle of the period, sin is junk before it.
  task automatic send_bit(input logic b, input int period, input bit chk_hold);
    for (int k = 0; k < period; k++) begin
      en  = (k == period - 1);
      sin = (k == period - 1) ? b : 1'($urandom);
      tick();
      if (chk_hold && dout !== model_dout) hold_bad = 1'b1;
    end
    en  = 1'b0;
    sin = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int period, input logic [7:0] exp_dout, input logic exp_dv,
                            input logic exp_pe, input logic exp_fe);
    hold_bad = 1'b0;
    send_bit(1'b0, period, 1);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 8; i++) send_bit(data[i], period, 1);
    send_bit(par, period, 1);
    check("dout_hold_in_frame", hold_bad, 0);
    send_bit(stop, period, 0);
    check("dout_valid", dout_valid, exp_dv);
    check("parity_err", parity_err, exp_pe);
    check("frame_err", frame_err, exp_fe);
    check("dout", dout, exp_dout);
    check("busy_after_stop", busy, !stop);
    exp_dv_total += exp_dv;
    exp_pe_total += exp_pe;
    exp_fe_total += exp_fe;
    model_dout = exp_dout;
    $display("frame data=%02h par=%0b stop=%0b period=%0d -> dout=%02h dv=%0b pe=%0b fe=%0b",
             data, par, stop, period, dout, dout_valid, parity_err, frame_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[7];
    logic [7:0] rd;
    logic       rp, rs, r_pe;
    int         rper;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h01, 1'b0, 1'b1, 1, 8'h01, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h5A, 1'b0, 1'b1, 4, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 2, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h07, 1'b1, 1'b1, 3, 8'h07, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b0, 1'b1, 1, 8'h80, 1'b1, 1'b1, 1'b0};

    rst = 1'b0;
    en  = 1'b1;
    sin = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check("rst_dout", dout, 0);
    check("rst_dv", dout_valid, 0);
    check("rst_pe", parity_err, 0);
    check("rst_fe", frame_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    en  = 1'b0;
    sin = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, vecs[v].period,
                 vecs[v].exp_dout, vecs[v].exp_dv, vecs[v].exp_pe, vecs[v].exp_fe);
      if (!vecs[v].stop) begin
        // Low samples in WAIT_HIGH must not be taken as a start bit.
        send_bit(1'b0, 1, 1);
        check("wait_high_hold_busy", busy, 1);
        send_bit(1'b0, 1, 1);
        send_bit(1'b1, 1, 1);
        check("wait_high_exit_busy", busy, 0);
        check("wait_high_dout_hold", hold_bad, 0);
      end
    end

    // Back-to-back frames, next start bit right after the stop bit.
    send_frame(8'h12, 1'b0, 1'b1, 1, 8'h12, 1'b1, 1'b0, 1'b0);
    send_frame(8'h34, 1'b1, 1'b1, 1, 8'h34, 1'b1, 1'b0, 1'b0);

    // Reset mid-frame, with en=1 and sin=0 present to show reset priority.
    send_bit(1'b0, 1, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1, 1);
    check("midframe_busy", busy, 1);
    rst = 1'b0;
    en  = 1'b1;
    sin = 1'b0;
    tick();
    check("midrst_dout", dout, 0);
    check("midrst_busy", busy, 0);
    check("midrst_dv", dout_valid, 0);
    rst = 1'b1;
    en  = 1'b1;
    sin = 1'b1;
    tick();
    check("post_rst_idle", busy, 0);
    en = 1'b0;
    model_dout = 8'h00;
    send_frame(8'h81, 1'b0, 1'b1, 1, 8'h81, 1'b1, 1'b0, 1'b0);

    // Random frames vs frame-level model.
    for (int n = 0; n < 40; n++) begin
      rd   = 8'($urandom);
      rp   = 1'($urandom);
      rs   = ($urandom_range(0, 4) != 0);
      rper = $urandom_range(1, 3);
      r_pe = 1'b0;
      for (int i = 0; i < 8; i++) r_pe = r_pe ^ rd[i];
      r_pe = r_pe ^ rp;
      if (rs) send_frame(rd, rp, rs, rper, rd, 1'b1, r_pe, 1'b0);
      else begin
        send_frame(rd, rp, rs, rper, model_dout, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1, rper, 1);
        check("rand_wait_exit", busy, 0);
      end
    end

    en  = 1'b0;
    sin = 1'b1;
    tick();
    tick();
    check("total_dv_pulses", dv_seen, exp_dv_total);
    check("total_fe_pulses", fe_seen, exp_fe_total);
    check("total_pe_pulses", pe_seen, exp_pe_total);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
